// File: rtl/alarm_sequencer_pkg.sv
// Shared constants for the alarm sequencer: state encodings, default PIN and
// the keypad-decoder codes of the PIN digits.
package alarm_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_DISARMED    = 3'd0;
  localparam state_t ST_EXIT_DELAY  = 3'd1;
  localparam state_t ST_ARMED       = 3'd2;
  localparam state_t ST_ENTRY_DELAY = 3'd3;
  localparam state_t ST_ALARM       = 3'd4;

  // Keypad decoder output for the four PIN keys
  localparam logic [3:0] KEY_A = 4'h3;
  localparam logic [3:0] KEY_B = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h9;
  localparam logic [3:0] KEY_9 = 4'hA;

  localparam logic [15:0] DEFAULT_CODE = {KEY_A, KEY_B, KEY_8, KEY_9};

  function automatic logic is_armed(input state_t s);
    return (s == ST_ARMED) || (s == ST_ENTRY_DELAY) || (s == ST_ALARM);
  endfunction

  function automatic logic is_alert(input state_t s);
    return (s == ST_ENTRY_DELAY) || (s == ST_ALARM);
  endfunction

endpackage

// File: rtl/alarm_sequencer_pin_entry.sv
// Collects 4-digit PIN entries; code_ok/code_bad are combinational pulses in
// the cycle the 4th digit arrives, so the FSM can register its reaction.
module pin_entry
  import alarm_sequencer_pkg::*;
#(
  parameter logic [15:0] CODE = DEFAULT_CODE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       code_ok,
  output logic       code_bad
);

  logic [11:0] hist;
  logic [1:0]  cnt;
  logic        last;
  logic        match;

  assign last     = key_valid && (cnt == 2'd3);
  assign match    = ({hist, key_code} == CODE);
  assign code_ok  = last && match;
  assign code_bad = last && !match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      cnt  <= '0;
    end else if (clr || last) begin
      hist <= '0;
      cnt  <= '0;
    end else if (key_valid) begin
      hist <= {hist[7:0], key_code};
      cnt  <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Arm/disarm sequencer: PIN-driven FSM with exit/entry delays, PIR
// synchronizer, wrong-code lockout and modulated siren.
module alarm_sequencer
  import alarm_sequencer_pkg::*;
#(
  parameter logic [15:0] EXIT_CYCLES  = 16'd50000,
  parameter logic [15:0] ENTRY_CYCLES = 16'd50000,
  parameter logic [15:0] SIREN_HALF   = 16'd25000,
  parameter logic [1:0]  MAX_TRIES    = 2'd3,
  parameter logic [15:0] CODE         = DEFAULT_CODE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pir_sensor,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic [2:0] state,
  output logic       armed,
  output logic       alerta_pin,
  output logic       bocina_pin,
  output logic       code_err
);

  logic        pir_meta, pir_sync;
  state_t      next_state;
  logic        state_chg;
  logic [15:0] timer;
  logic [15:0] siren_cnt;
  logic [1:0]  fails;
  logic        code_ok, code_bad;
  logic        motion, lockout, exit_done, entry_done;

  assign motion     = !pir_sync;
  assign state_chg  = (next_state != state);
  assign exit_done  = (timer == EXIT_CYCLES - 16'd1);
  assign entry_done = (timer == ENTRY_CYCLES - 16'd1);
  assign lockout    = code_bad && ((fails + 2'd1) == MAX_TRIES);

  // Any state change discards a partially typed PIN
  pin_entry #(.CODE(CODE)) u_pin (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_chg),
    .key_code  (key_code),
    .key_valid (key_valid),
    .code_ok   (code_ok),
    .code_bad  (code_bad)
  );

  // A correct code always takes priority over timer expiry and motion
  always_comb begin
    next_state = state;
    case (state)
      ST_DISARMED:    if (code_ok) next_state = ST_EXIT_DELAY;
      ST_EXIT_DELAY:  if (code_ok) next_state = ST_DISARMED;
                      else if (exit_done) next_state = ST_ARMED;
      ST_ARMED:       if (code_ok) next_state = ST_DISARMED;
                      else if (motion) next_state = ST_ENTRY_DELAY;
      ST_ENTRY_DELAY: if (code_ok) next_state = ST_DISARMED;
                      else if (entry_done || lockout) next_state = ST_ALARM;
      ST_ALARM:       if (code_ok) next_state = ST_DISARMED;
      default:        next_state = ST_DISARMED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pir_meta   <= 1'b1;
      pir_sync   <= 1'b1;
      state      <= ST_DISARMED;
      armed      <= 1'b0;
      alerta_pin <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      pir_meta   <= pir_sensor;
      pir_sync   <= pir_meta;
      state      <= next_state;
      armed      <= is_armed(next_state);
      alerta_pin <= is_alert(next_state);
      code_err   <= code_bad;
    end
  end

  // Timer only runs in the two delay states and restarts on every entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (state_chg ||
                 !((state == ST_EXIT_DELAY) || (state == ST_ENTRY_DELAY))) begin
      timer <= '0;
    end else begin
      timer <= timer + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fails <= '0;
    end else if (state_chg &&
                 ((next_state == ST_DISARMED) || (next_state == ST_ARMED))) begin
      fails <= '0;
    end else if ((state == ST_ENTRY_DELAY) && code_bad) begin
      fails <= fails + 2'd1;
    end
  end

  // Siren starts high on ALARM entry and toggles every SIREN_HALF cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bocina_pin <= 1'b0;
      siren_cnt  <= '0;
    end else if (next_state == ST_ALARM) begin
      if (state != ST_ALARM) begin
        bocina_pin <= 1'b1;
        siren_cnt  <= '0;
      end else if (siren_cnt == SIREN_HALF - 16'd1) begin
        bocina_pin <= ~bocina_pin;
        siren_cnt  <= '0;
      end else begin
        siren_cnt  <= siren_cnt + 16'd1;
      end
    end else begin
      bocina_pin <= 1'b0;
      siren_cnt  <= '0;
    end
  end

endmodule
